// File: rtl/mtc_sched_pkg.sv
// Shared types, defaults and the saturating-counter helper for the pT-calc to MTC scheduler.
// PTCALC2MTC_LEN mirrors the value of the same name in the buses constants header.
package mtc_sched_pkg;

  localparam int PTCALC2MTC_LEN = 32;
  localparam int MAX_THREADS    = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_CNT_WIDTH  = 16;

  // Wide enough for the largest supported thread count.
  typedef logic [2:0] thread_idx_t;

  // Increment value, saturating at the all-ones pattern of the low 'width' bits (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] ceiling;
    ceiling = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= ceiling) ? ceiling : (value + 32'd1);
  endfunction

endpackage

// File: rtl/mtc_sched_fifo.sv
// Single-clock per-thread FIFO with registered pointers, full/empty flags and no fall-through.
// Pointers carry one extra wrap bit so a full FIFO and an empty FIFO can be told apart.
module mtc_sched_fifo
  import mtc_sched_pkg::*;
#(
  parameter int WIDTH = PTCALC2MTC_LEN,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/mtc_ptcalc_scheduler.sv
// Round-robin scheduler sharing one MTC builder input slot between pT-calc thread FIFOs.
// Optional per-thread grant counters are built when MTC_SCHED_STATS_EN is defined.
module mtc_ptcalc_scheduler
  import mtc_sched_pkg::*;
#(
  parameter int PTCALC_WIDTH  = PTCALC2MTC_LEN,
  parameter int c_NUM_THREADS = 3,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
  localparam int TW           = (c_NUM_THREADS > 1) ? $clog2(c_NUM_THREADS) : 1
) (
  input  logic                                clock,
  input  logic                                rst,
  input  logic [PTCALC_WIDTH*c_NUM_THREADS-1:0] ptcalc,
  input  logic [c_NUM_THREADS-1:0]            ptcalc_valid,
  output logic [PTCALC_WIDTH-1:0]             mtc_out,
  output logic                                mtc_out_valid,
  input  logic                                mtc_out_ready,
  output logic [TW-1:0]                       mtc_out_thread,
  output logic [c_NUM_THREADS-1:0]            overflow,
  output logic [CNT_WIDTH*c_NUM_THREADS-1:0]  drop_cnt
`ifdef MTC_SCHED_STATS_EN
  ,
  output logic [CNT_WIDTH*c_NUM_THREADS-1:0]  grant_cnt
`endif
);

  logic [c_NUM_THREADS-1:0] full;
  logic [c_NUM_THREADS-1:0] empty;
  logic [c_NUM_THREADS-1:0] pop;
  logic [c_NUM_THREADS-1:0] drop;
  logic [PTCALC_WIDTH-1:0]  rd_data [c_NUM_THREADS];
  logic [PTCALC_WIDTH-1:0]  sel_data;
  logic [MAX_THREADS-1:0]   empty_pad;
  thread_idx_t              rr;
  thread_idx_t              grant;
  thread_idx_t              next_rr;
  thread_idx_t              idx;
  logic                     take;
  logic                     hit;
  logic                     load_en;

  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] value);
    logic [31:0] wide;
    wide                = '0;
    wide[CNT_WIDTH-1:0] = value;
    wide                = sat_inc(wide, CNT_WIDTH);
    return wide[CNT_WIDTH-1:0];
  endfunction

  generate
    for (genvar i = 0; i < c_NUM_THREADS; i++) begin : g_fifo
      mtc_sched_fifo #(
        .WIDTH (PTCALC_WIDTH),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clock     (clock),
        .rst       (rst),
        .push      (ptcalc_valid[i]),
        .push_data (ptcalc[i*PTCALC_WIDTH +: PTCALC_WIDTH]),
        .pop       (pop[i]),
        .pop_data  (rd_data[i]),
        .full      (full[i]),
        .empty     (empty[i])
      );
    end
  endgenerate

  // Output slot may take a new word when it is empty or its word leaves this cycle.
  assign load_en = !mtc_out_valid || mtc_out_ready;

  // Round-robin search from rr, pop selection and drop detection.
  always_comb begin
    empty_pad                    = {MAX_THREADS{1'b1}};
    empty_pad[c_NUM_THREADS-1:0] = empty;
    hit                          = 1'b0;
    grant                        = '0;
    idx                          = '0;
    take                         = 1'b0;
    for (int off = 0; off < c_NUM_THREADS; off++) begin
      idx   = thread_idx_t'((int'(rr) + off) % c_NUM_THREADS);
      take  = !hit && !empty_pad[idx];
      grant = take ? idx : grant;
      hit   = hit || take;
    end
    next_rr  = thread_idx_t'((int'(grant) + 1) % c_NUM_THREADS);
    sel_data = '0;
    pop      = '0;
    drop     = '0;
    for (int i = 0; i < c_NUM_THREADS; i++) begin
      sel_data = (grant == thread_idx_t'(i)) ? rd_data[i] : sel_data;
      pop[i]   = load_en && hit && (grant == thread_idx_t'(i));
      drop[i]  = ptcalc_valid[i] && full[i] && !pop[i];
    end
  end

  // Output register and round-robin pointer; the held word is stable while not accepted.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      mtc_out        <= '0;
      mtc_out_valid  <= 1'b0;
      mtc_out_thread <= '0;
      rr             <= '0;
    end else if (load_en) begin
      if (hit) begin
        mtc_out        <= sel_data;
        mtc_out_valid  <= 1'b1;
        mtc_out_thread <= grant[TW-1:0];
        rr             <= next_rr;
      end else begin
        mtc_out_valid  <= 1'b0;
      end
    end
  end

  // Overflow pulses and saturating per-thread drop counters.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      overflow <= '0;
      drop_cnt <= '0;
    end else begin
      overflow <= drop;
      for (int i = 0; i < c_NUM_THREADS; i++) begin
        if (drop[i]) begin
          drop_cnt[i*CNT_WIDTH +: CNT_WIDTH] <= bump(drop_cnt[i*CNT_WIDTH +: CNT_WIDTH]);
        end
      end
    end
  end

`ifdef MTC_SCHED_STATS_EN
  // Saturating count of words accepted downstream, per source thread.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (mtc_out_valid && mtc_out_ready) begin
      for (int i = 0; i < c_NUM_THREADS; i++) begin
        if (mtc_out_thread == TW'(i)) begin
          grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] <= bump(grant_cnt[i*CNT_WIDTH +: CNT_WIDTH]);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_mtc_ptcalc_scheduler.sv
// Scoreboard bench for mtc_ptcalc_scheduler: expected words are queued when driven and
// compared when accepted downstream; directed checks cover latency, hold, drops and reset.
module tb_mtc_ptcalc_scheduler;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int CW = 4;
  localparam int TW = 2;

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] thr;
  } exp_t;

  logic              clock = 1'b0;
  logic              rst   = 1'b1;
  logic [W*N-1:0]    ptcalc;
  logic [N-1:0]      ptcalc_valid;
  logic [W-1:0]      mtc_out;
  logic              mtc_out_valid;
  logic              mtc_out_ready;
  logic [TW-1:0]     mtc_out_thread;
  logic [N-1:0]      overflow;
  logic [CW*N-1:0]   drop_cnt;
`ifdef MTC_SCHED_STATS_EN
  logic [CW*N-1:0]   grant_cnt;
`endif

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   xfers = 0;
  int   span_mark = 0;
  int   first_cyc = 0;
  int   last_cyc  = 0;
  int   ovf_seen [N];
  int   ovf_base [N];
  bit   mon_en = 1'b1;
  exp_t sb [$];
  exp_t mon_e;

  mtc_ptcalc_scheduler #(
    .PTCALC_WIDTH  (W),
    .c_NUM_THREADS (N),
    .FIFO_DEPTH    (4),
    .CNT_WIDTH     (CW)
  ) dut (
    .clock          (clock),
    .rst            (rst),
    .ptcalc         (ptcalc),
    .ptcalc_valid   (ptcalc_valid),
    .mtc_out        (mtc_out),
    .mtc_out_valid  (mtc_out_valid),
    .mtc_out_ready  (mtc_out_ready),
    .mtc_out_thread (mtc_out_thread),
    .overflow       (overflow),
    .drop_cnt       (drop_cnt)
`ifdef MTC_SCHED_STATS_EN
    ,
    .grant_cnt      (grant_cnt)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer and overflow pulse counter.
  always @(negedge clock) begin
    if (mon_en && !rst) begin
      for (int i = 0; i < N; i++) begin
        if (overflow[i]) ovf_seen[i]++;
      end
      if (mtc_out_valid && mtc_out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(1), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          chk("sb_data", 64'(mtc_out), 64'(mon_e.data));
          chk("sb_thread", 64'(mtc_out_thread), 64'(mon_e.thr));
        end
        if (xfers == span_mark) first_cyc = cyc;
        last_cyc = cyc;
        xfers++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] d2);
    ptcalc_valid = v;
    ptcalc       = {d2, d1, d0};
  endtask

  task automatic expect_word(input logic [W-1:0] d, input int t);
    exp_t x;
    x.data = d;
    x.thr  = TW'(t);
    sb.push_back(x);
  endtask

  task automatic snap();
    for (int i = 0; i < N; i++) ovf_base[i] = ovf_seen[i];
    span_mark = xfers;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    ptcalc_valid  = '0;
    mtc_out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    snap();
  endtask

  task automatic drain(input int budget);
    int n;
    n             = 0;
    mtc_out_ready = 1'b1;
    ptcalc_valid  = '0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'(0));
    tick();
    chk("drain_idle", 64'(mtc_out_valid), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      ovf_seen[i] = 0;
      ovf_base[i] = 0;
    end
    ptcalc        = '0;
    ptcalc_valid  = '0;
    mtc_out_ready = 1'b0;
    #12;
    chk("rst_out", 64'(mtc_out), 64'(0));
    chk("rst_valid", 64'(mtc_out_valid), 64'(0));
    chk("rst_thread", 64'(mtc_out_thread), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));
`ifdef MTC_SCHED_STATS_EN
    chk("rst_grant", 64'(grant_cnt), 64'(0));
`endif
    do_reset();

    // single word on thread 1: visible exactly two edges after being driven
    mtc_out_ready = 1'b1;
    drive(3'b010, '0, 32'hA5, '0);
    expect_word(32'hA5, 1);
    tick();
    drive(3'b000, '0, '0, '0);
    chk("t1_early_valid", 64'(mtc_out_valid), 64'(0));
    tick();
    chk("t1_valid", 64'(mtc_out_valid), 64'(1));
    chk("t1_data", 64'(mtc_out), 64'(32'hA5));
    chk("t1_thread", 64'(mtc_out_thread), 64'(1));
    tick();
    chk("t1_after", 64'(mtc_out_valid), 64'(0));

    // three threads push four words each in lockstep: strict rotation, no bubbles
    do_reset();
    mtc_out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      drive(3'b111, 32'hC000_0000 + 32'(j), 32'hC000_0100 + 32'(j), 32'hC000_0200 + 32'(j));
      expect_word(32'hC000_0000 + 32'(j), 0);
      expect_word(32'hC000_0100 + 32'(j), 1);
      expect_word(32'hC000_0200 + 32'(j), 2);
      tick();
    end
    drain(40);
    chk("t2_xfers", 64'(xfers - span_mark), 64'(12));
    chk("t2_span", 64'(last_cyc - first_cyc), 64'(11));
    for (int i = 0; i < N; i++) chk("t2_no_ovf", 64'(ovf_seen[i] - ovf_base[i]), 64'(0));
`ifdef MTC_SCHED_STATS_EN
    chk("t2_grant", 64'(grant_cnt), 64'(12'h444));
`endif

    // back-pressure: slot holds a thread-1 word while thread 0 overfills its FIFO
    do_reset();
    drive(3'b010, '0, 32'hB1, '0);
    expect_word(32'hB1, 1);
    tick();
    for (int j = 0; j < 6; j++) begin
      drive(3'b001, 32'hD0 + 32'(j), '0, '0);
      if (j < 4) expect_word(32'hD0 + 32'(j), 0);
      tick();
      chk("t3_hold_data", 64'(mtc_out), 64'(32'hB1));
      chk("t3_hold_thr", 64'(mtc_out_thread), 64'(1));
    end
    ptcalc_valid = '0;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("t3_hold_data", 64'(mtc_out), 64'(32'hB1));
    end
    chk("t3_ovf_pulses", 64'(ovf_seen[0] - ovf_base[0]), 64'(2));
    chk("t3_drop_cnt", 64'(drop_cnt[CW-1:0]), 64'(2));
    drain(40);

    // full FIFO popped and pushed in the same edge: no drop, still full afterwards
    do_reset();
    for (int j = 0; j < 5; j++) begin
      drive(3'b001, 32'hE0 + 32'(j), '0, '0);
      expect_word(32'hE0 + 32'(j), 0);
      tick();
    end
    drive(3'b001, 32'hE5, '0, '0);
    expect_word(32'hE5, 0);
    mtc_out_ready = 1'b1;
    tick();
    chk("t4_no_ovf", 64'(overflow), 64'(0));
    drive(3'b001, 32'hE6, '0, '0);
    mtc_out_ready = 1'b0;
    tick();
    chk("t4_still_full", 64'(overflow), 64'(3'b001));
    chk("t4_drop_cnt", 64'(drop_cnt[CW-1:0]), 64'(1));
    drain(40);

    // drop counter saturation on thread 2: twenty drops into a 4-bit counter
    do_reset();
    for (int j = 0; j < 25; j++) begin
      drive(3'b100, '0, '0, 32'hF00 + 32'(j));
      if (j < 5) expect_word(32'hF00 + 32'(j), 2);
      tick();
    end
    ptcalc_valid = '0;
    tick();
    chk("t5_pulses", 64'(ovf_seen[2] - ovf_base[2]), 64'(20));
    chk("t5_sat", 64'(drop_cnt[2*CW +: CW]), 64'(15));
    chk("t5_others", 64'(drop_cnt[2*CW-1:0]), 64'(0));
    tick();
    tick();
    chk("t5_held", 64'(drop_cnt[2*CW +: CW]), 64'(15));
    drain(40);

    // asynchronous reset mid-burst clears everything before the next edge
    mon_en        = 1'b0;
    mtc_out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      drive(3'b111, 32'h100 + 32'(j), 32'h200 + 32'(j), 32'h300 + 32'(j));
      tick();
    end
    chk("t6_pre_valid", 64'(mtc_out_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("t6_out", 64'(mtc_out), 64'(0));
    chk("t6_valid", 64'(mtc_out_valid), 64'(0));
    chk("t6_thread", 64'(mtc_out_thread), 64'(0));
    chk("t6_ovf", 64'(overflow), 64'(0));
    chk("t6_drop", 64'(drop_cnt), 64'(0));
`ifdef MTC_SCHED_STATS_EN
    chk("t6_grant", 64'(grant_cnt), 64'(0));
`endif
    ptcalc_valid = '0;
    tick();
    tick();
    rst    = 1'b0;
    mon_en = 1'b1;
    snap();
    drive(3'b001, 32'h77, '0, '0);
    expect_word(32'h77, 0);
    tick();
    drive(3'b000, '0, '0, '0);
    chk("t6_early_valid", 64'(mtc_out_valid), 64'(0));
    tick();
    chk("t6_valid_lat", 64'(mtc_out_valid), 64'(1));
    chk("t6_data_lat", 64'(mtc_out), 64'(32'h77));
    tick();
    chk("t6_after", 64'(mtc_out_valid), 64'(0));
    chk("t6_sb_empty", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
